// File: rtl/vec_driver_pkg.sv
// vec_driver_pkg: shared types and constants for the vec_driver block.
//   state_t   : control FSM encoding (SHIFT / WAIT / REPORT)
//   DEF_WIDTH : default number of DUT data inputs
//   BIT_CNT_W : frame bit counter width for the default WIDTH
//   WCNT_W    : latency wait counter width (LAT is 1..15)
package vec_driver_pkg;

  typedef enum logic [1:0] {
    SHIFT  = 2'd0,
    WAIT   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 25;
  localparam int BIT_CNT_W = $clog2(DEF_WIDTH + 1);
  localparam int WCNT_W    = 4;

endpackage

// File: rtl/vec_driver_if.sv
// vec_driver_if: serial frame input and result output of vec_driver.
//   sdi, sdi_valid, sdi_ready        : serial frame channel (host -> driver)
//   res_valid, res_ready, res_bit,
//   res_match                        : result channel (driver -> host)
//
// Handshake rule for both channels: a transfer happens on a rising edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until the transfer; ready may be asserted without valid.
// sdi_ready is decoded from state only and never depends on sdi_valid.
interface vec_driver_if;

  logic sdi;
  logic sdi_valid;
  logic sdi_ready;
  logic res_valid;
  logic res_ready;
  logic res_bit;
  logic res_match;

  modport master (
    output sdi, sdi_valid, res_ready,
    input  sdi_ready, res_valid, res_bit, res_match
  );

  modport slave (
    input  sdi, sdi_valid, res_ready,
    output sdi_ready, res_valid, res_bit, res_match
  );

endinterface

// File: rtl/vec_driver_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk : clock
//   rst : asynchronous active-low reset
//   clr : synchronous clear, has priority over inc
//   inc : count enable, ignored once the counter is all-ones
//   cnt : counter value
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vec_driver.sv
// vec_driver: deserialises a WIDTH+1 bit frame into a parallel vector for a
// registered single-output DUT, waits LAT edges, samples the DUT output,
// compares it with the expected bit from the frame and reports the result.
//   clk       : clock, all state on rising edge
//   rst       : asynchronous active-low reset
//   clr       : synchronous clear of vec_cnt / err_cnt
//   link      : serial frame in / result out (vec_driver_if.slave)
//   vec_out   : parallel vector to the DUT (bit 0 -> a)
//   dut_on    : DUT enable, high from load until the result handshake
//   dut_out   : DUT registered output
//   vec_cnt   : completed vectors, saturating
//   err_cnt   : mismatching vectors, saturating
//   busy      : high whenever the frame input is not being accepted
//   dbg_state : current FSM state
// LAT must lie in 1..15 (wait counter is WCNT_W bits).
module vec_driver
  import vec_driver_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  vec_driver_if.slave      link,
  output logic [WIDTH-1:0] vec_out,
  output logic             dut_on,
  input  logic             dut_out,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int BC_W = $clog2(WIDTH + 1);

  state_t            state, state_nxt;
  logic [BC_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]  shreg;
  logic [WCNT_W-1:0] wcnt;
  logic              exp_bit;
  logic              res_valid_q;
  logic              res_bit_q;
  logic              res_match_q;

  logic              accept;
  logic              load;
  logic              sample;
  logic              handshake;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SHIFT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-edge strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    sample    = 1'b0;
    handshake = 1'b0;
    unique case (state)
      SHIFT: begin
        accept = link.sdi_valid;
        // The final frame bit is the expected response; accepting it loads
        // the vector and starts the latency wait.
        if (link.sdi_valid && (bit_cnt == BC_W'(WIDTH))) begin
          load      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == WCNT_W'(LAT - 1)) begin
          sample    = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (link.res_ready) begin
          handshake = 1'b1;
          state_nxt = SHIFT;
        end
      end
      default: state_nxt = SHIFT;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      wcnt        <= '0;
      exp_bit     <= 1'b0;
      vec_out     <= '0;
      dut_on      <= 1'b0;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      res_match_q <= 1'b0;
    end else begin
      if (accept) begin
        if (load) begin
          // All vector bits were captured on earlier edges; only the
          // expected bit arrives on this one.
          vec_out <= shreg;
          exp_bit <= link.sdi;
          dut_on  <= 1'b1;
          wcnt    <= '0;
          bit_cnt <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt == BC_W'(i)) begin
              shreg[i] <= link.sdi;
            end
          end
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (state == WAIT) begin
        wcnt <= wcnt + 1'b1;
      end
      if (sample) begin
        res_bit_q   <= dut_out;
        res_match_q <= (dut_out == exp_bit);
        res_valid_q <= 1'b1;
      end
      if (handshake) begin
        res_valid_q <= 1'b0;
        dut_on      <= 1'b0;
      end
    end
  end

  assign link.sdi_ready = (state == SHIFT);
  assign link.res_valid = res_valid_q;
  assign link.res_bit   = res_bit_q;
  assign link.res_match = res_match_q;
  assign busy           = (state != SHIFT);
  assign dbg_state      = state;

  sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (handshake),
    .cnt (vec_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (handshake && !res_match_q),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_vec_driver.sv
// tb_vec_driver: bench for vec_driver. Instance 0 uses LAT=2/CNT_W=16 with a
// one-register parity DUT model; instance 1 uses LAT=1/CNT_W=2 with a
// bench-driven dut_out for the sampling-edge and saturation corners.
module tb_vec_driver;
  import vec_driver_pkg::*;

  localparam int W  = 25;
  localparam int CW = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus, steered to one instance by sel
  logic clr       = 1'b0;
  logic sdi       = 1'b0;
  logic sdi_valid = 1'b0;
  logic res_ready = 1'b0;
  logic sel       = 1'b0;
  logic inject    = 1'b0;

  vec_driver_if bus0();
  vec_driver_if bus1();

  assign bus0.sdi       = sdi;
  assign bus0.sdi_valid = sdi_valid & ~sel;
  assign bus0.res_ready = res_ready & ~sel;
  assign bus1.sdi       = sdi;
  assign bus1.sdi_valid = sdi_valid & sel;
  assign bus1.res_ready = res_ready & sel;

  logic [W-1:0]  vec_out0, vec_out1;
  logic          dut_on0, dut_on1;
  logic          dut_out0;
  logic          dut_out1 = 1'b1;
  logic [CW-1:0] vec_cnt0, err_cnt0;
  logic [1:0]    vec_cnt1, err_cnt1;
  logic          busy0, busy1;
  state_t        st0, st1;

  vec_driver #(.WIDTH(W), .LAT(2), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .link(bus0),
    .vec_out(vec_out0), .dut_on(dut_on0), .dut_out(dut_out0),
    .vec_cnt(vec_cnt0), .err_cnt(err_cnt0), .busy(busy0), .dbg_state(st0)
  );

  vec_driver #(.WIDTH(W), .LAT(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .link(bus1),
    .vec_out(vec_out1), .dut_on(dut_on1), .dut_out(dut_out1),
    .vec_cnt(vec_cnt1), .err_cnt(err_cnt1), .busy(busy1), .dbg_state(st1)
  );

  // Registered DUT model for instance 0: one register of vector parity,
  // optionally inverted to create mismatches.
  logic dut_q;
  always @(posedge clk) dut_q <= (^vec_out0) ^ inject;
  assign dut_out0 = dut_q;

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  int m_vec0 = 0, m_err0 = 0, m_vec1 = 0, m_err1 = 0;
  logic [1:0] exp_q[$];  // {res_bit, res_match}

  typedef struct {
    logic [W-1:0] vec;
    logic         exp_bit;
    logic         inj;
    bit           gaps;
    int           bp;
    logic         res_bit;
    logic         res_match;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Driver: one frame, LSB first, expected bit last. Entered and left #1
  // after a rising edge; returns just after the load edge.
  task automatic send_frame(input logic [W-1:0] v, input logic e, input bit gaps);
    logic [W:0] f;
    f = {e, v};
    for (int i = 0; i <= W; i++) begin
      if (gaps) begin
        sdi       = ~f[i];
        sdi_valid = 1'b0;
        @(posedge clk); #1;
      end
      sdi       = f[i];
      sdi_valid = 1'b1;
      @(posedge clk); #1;
    end
    sdi_valid = 1'b0;
  endtask

  task automatic run_vector(input logic [W-1:0] v, input logic e, input logic inj,
                            input bit gaps, input int bp);
    logic [1:0] ex;
    int lat;
    check("idle_ready", 32'(bus0.sdi_ready), 32'd1);
    inject = inj;
    send_frame(v, e, gaps);
    check("vec_load", 32'(vec_out0), 32'(v));
    check("dut_on_load", 32'(dut_on0), 32'd1);
    check("busy_load", 32'(busy0), 32'd1);
    lat = 0;
    while (!bus0.res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd2);
    ex = exp_q.pop_front();
    if (bus0.res_valid) begin
      check("res_bit", 32'(bus0.res_bit), 32'(ex[1]));
      check("res_match", 32'(bus0.res_match), 32'(ex[0]));
      // Back-pressure with garbage on the frame input, which must be ignored
      for (int k = 0; k < bp; k++) begin
        sdi       = 1'b1;
        sdi_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_valid", 32'(bus0.res_valid), 32'd1);
        check("bp_bit", 32'(bus0.res_bit), 32'(ex[1]));
        check("bp_match", 32'(bus0.res_match), 32'(ex[0]));
        check("bp_ready", 32'(bus0.sdi_ready), 32'd0);
        check("bp_err_cnt", 32'(err_cnt0), 32'(m_err0));
      end
      sdi_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      m_vec0++;
      if (!ex[0]) m_err0++;
      check("hs_valid", 32'(bus0.res_valid), 32'd0);
      check("hs_dut_on", 32'(dut_on0), 32'd0);
      check("hs_busy", 32'(busy0), 32'd0);
      check("vec_hold", 32'(vec_out0), 32'(v));
      check("vec_cnt", 32'(vec_cnt0), 32'(m_vec0));
      check("err_cnt", 32'(err_cnt0), 32'(m_err0));
    end
  endtask

  // LAT=1 instance: dut_out1 is 1 before the first WAIT edge and changes to
  // 0 exactly on that edge, so a correct sample reads 1 (a mismatch, exp=0).
  task automatic run_lat1(input logic [W-1:0] v, input bit do_clr);
    dut_out1 <= 1'b1;
    check("l1_ready", 32'(bus1.sdi_ready), 32'd1);
    send_frame(v, 1'b0, 1'b0);
    check("l1_vec", 32'(vec_out1), 32'(v));
    check("l1_not_early", 32'(bus1.res_valid), 32'd0);
    @(posedge clk);
    dut_out1 <= 1'b0;
    #1;
    check("l1_latency", 32'(bus1.res_valid), 32'd1);
    check("l1_res_bit", 32'(bus1.res_bit), 32'd1);
    check("l1_res_match", 32'(bus1.res_match), 32'd0);
    clr       = do_clr;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    clr       = 1'b0;
    if (do_clr) begin
      m_vec1 = 0; m_err1 = 0; m_vec0 = 0; m_err0 = 0;
    end else begin
      if (m_vec1 < 3) m_vec1++;
      if (m_err1 < 3) m_err1++;
    end
    check("l1_hs_valid", 32'(bus1.res_valid), 32'd0);
    check("l1_vec_cnt", 32'(vec_cnt1), 32'(m_vec1));
    check("l1_err_cnt", 32'(err_cnt1), 32'(m_err1));
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] v;
    logic e, inj, rb;
    bit seen;

    tbl[0] = '{25'h1555555, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1};
    tbl[1] = '{25'h1555555, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0};
    tbl[2] = '{25'h0000001, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    tbl[3] = '{25'h0000001, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    tbl[4] = '{25'h0000000, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    tbl[5] = '{25'h1FFFFFF, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0};
    tbl[6] = '{25'h0000003, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1};

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(st0), 32'(SHIFT));
    check("rst_sdi_ready", 32'(bus0.sdi_ready), 32'd1);
    check("rst_vec_out", 32'(vec_out0), 32'd0);
    check("rst_dut_on", 32'(dut_on0), 32'd0);
    check("rst_res_valid", 32'(bus0.res_valid), 32'd0);
    check("rst_res_bit", 32'(bus0.res_bit), 32'd0);
    check("rst_res_match", 32'(bus0.res_match), 32'd0);
    check("rst_vec_cnt", 32'(vec_cnt0), 32'd0);
    check("rst_err_cnt", 32'(err_cnt0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_vec_out1", 32'(vec_out1), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({tbl[i].res_bit, tbl[i].res_match});
      run_vector(tbl[i].vec, tbl[i].exp_bit, tbl[i].inj, tbl[i].gaps, tbl[i].bp);
    end

    // Reset one cycle after a load: nothing of that frame may survive
    inject = 1'b0;
    send_frame(25'h0ABCDEF, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    m_vec0 = 0; m_err0 = 0; m_vec1 = 0; m_err1 = 0;
    check("mrst_state", 32'(st0), 32'(SHIFT));
    check("mrst_vec_out", 32'(vec_out0), 32'd0);
    check("mrst_dut_on", 32'(dut_on0), 32'd0);
    check("mrst_res_valid", 32'(bus0.res_valid), 32'd0);
    check("mrst_vec_cnt", 32'(vec_cnt0), 32'd0);
    check("mrst_err_cnt", 32'(err_cnt0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_sdi_ready", 32'(bus0.sdi_ready), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus0.res_valid) seen = 1'b1;
    end
    check("mrst_no_result", 32'(seen), 32'd0);

    // Randomized frames against the parity reference
    for (int n = 0; n < 16; n++) begin
      v   = W'($urandom);
      e   = 1'($urandom_range(0, 1));
      inj = 1'($urandom_range(0, 1));
      rb  = (($countones(v) % 2) == 1) ^ inj;
      exp_q.push_back({rb, rb == e});
      run_vector(v, e, inj, bit'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // LAT=1 sampling edge and 2-bit counter saturation, then clr vs handshake
    sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_lat1(W'($urandom), 1'b0);
    end
    run_lat1(25'h1234567, 1'b1);
    check("clr_vec_cnt0", 32'(vec_cnt0), 32'(m_vec0));
    check("clr_err_cnt0", 32'(err_cnt0), 32'(m_err0));
    sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
